// File: rtl/spi_rom_responder.sv
// spi_rom_responder: SPI mode-0 serial ROM read responder (0x03 single-bit read, continuous).
// Define QUAD_READ_EN to add 0x6B quad-output read; the pad output bus is named dout since do is reserved.
module spi_rom_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_n,
  input  logic        sclk,
  input  logic [3:0]  di,
  output logic [3:0]  dout,
  output logic [3:0]  oeb,
  output logic [23:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        active
);

  localparam logic [7:0] READ_CMD = 8'h03;
`ifdef QUAD_READ_EN
  localparam logic [7:0] QUAD_CMD = 8'h6B;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
`else
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;
`endif

  state_t state, next_state;

  logic [1:0]  cs_sync;
  logic [1:0]  sclk_sync;
  logic [3:0]  di_meta;
  logic [3:0]  di_sync;
  logic        cs_prev;
  logic        sclk_prev;
  logic        cs_s;
  logic        sclk_s;
  logic        io0;
  logic        sclk_rise;
  logic        sclk_fall;
  logic        cs_fall;
  logic        unused_io;

  logic [1:0]  prime_cnt;
  logic        primed;
  logic        armed;
  logic        start;
  logic        live;

  logic [4:0]  bit_cnt;
  logic [4:0]  last_slot;
  logic [6:0]  cmd_sr;
  logic [22:0] addr_sr;
  logic [7:0]  cmd_shift;
  logic [23:0] addr_shift;
  logic        cmd_bit;
  logic        cmd_done;
  logic        addr_bit;
  logic        addr_done;
  logic        data_step;
  logic        byte_done;
  logic        field_end;
  logic        field_step;
`ifdef QUAD_READ_EN
  logic        quad_mode;
  logic        dummy_bit;
  logic        dummy_done;
`endif

  logic [7:0]  data_sr;
  logic [3:0]  do_reg;
  logic        load_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      di_meta   <= 4'h0;
      di_sync   <= 4'h0;
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], cs_n};
      sclk_sync <= {sclk_sync[0], sclk};
      di_meta   <= di;
      di_sync   <= di_meta;
      cs_prev   <= cs_sync[1];
      sclk_prev <= sclk_sync[1];
    end
  end

  assign cs_s      = cs_sync[1];
  assign sclk_s    = sclk_sync[1];
  assign io0       = di_sync[0];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = cs_prev & ~cs_s;
  assign active    = ~cs_s;
  // io1..io3 are output-only in every supported command
  assign unused_io = ^di_sync[3:1];

  // A transaction may only start after cs_n has genuinely been seen high since reset,
  // so a select held low across rst cannot be mistaken for a fresh falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prime_cnt <= 2'd0;
      armed     <= 1'b0;
    end else begin
      if (!primed)
        prime_cnt <= prime_cnt + 2'd1;
      if (primed && cs_s)
        armed <= 1'b1;
    end
  end

  assign primed     = (prime_cnt == 2'd2);
  assign live       = ~cs_s;
  assign start      = (state == IDLE) && armed && cs_fall;
  assign cmd_shift  = {cmd_sr, io0};
  assign addr_shift = {addr_sr, io0};
  assign cmd_bit    = live && sclk_rise && (state == CMD);
  assign cmd_done   = cmd_bit && (bit_cnt == 5'd7);
  assign addr_bit   = live && sclk_rise && (state == ADDR);
  assign addr_done  = addr_bit && (bit_cnt == 5'd23);
  assign data_step  = live && sclk_fall && (state == DATA);
  assign byte_done  = data_step && (bit_cnt == last_slot);

`ifdef QUAD_READ_EN
  assign dummy_bit  = live && sclk_rise && (state == DUMMY);
  assign dummy_done = dummy_bit && (bit_cnt == 5'd7);
  assign last_slot  = quad_mode ? 5'd1 : 5'd7;
  assign field_end  = start | cmd_done | addr_done | dummy_done | byte_done;
  assign field_step = cmd_bit | addr_bit | dummy_bit | data_step;
`else
  assign last_slot  = 5'd7;
  assign field_end  = start | cmd_done | addr_done | byte_done;
  assign field_step = cmd_bit | addr_bit | data_step;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    oeb        = 4'hF;
    if (cs_s) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (start) next_state = CMD;
        CMD: begin
          if (cmd_done) begin
            if (cmd_shift == READ_CMD)
              next_state = ADDR;
`ifdef QUAD_READ_EN
            else if (cmd_shift == QUAD_CMD)
              next_state = ADDR;
`endif
            else
              next_state = IGNORE;
          end
        end
        ADDR: begin
          if (addr_done) begin
`ifdef QUAD_READ_EN
            next_state = quad_mode ? DUMMY : DATA;
`else
            next_state = DATA;
`endif
          end
        end
`ifdef QUAD_READ_EN
        DUMMY: if (dummy_done) next_state = DATA;
`endif
        default: next_state = state;
      endcase
    end
    if (state == DATA) begin
`ifdef QUAD_READ_EN
      oeb = quad_mode ? 4'h0 : 4'b1101;
`else
      oeb = 4'b1101;
`endif
    end
  end

  // One counter serves every field; it restarts at each field boundary.
  always_ff @(posedge clk) begin
    if (rst)
      bit_cnt <= 5'd0;
    else if (field_end)
      bit_cnt <= 5'd0;
    else if (field_step)
      bit_cnt <= bit_cnt + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_sr  <= 7'd0;
      addr_sr <= 23'd0;
    end else if (start) begin
      cmd_sr  <= 7'd0;
      addr_sr <= 23'd0;
    end else begin
      if (cmd_bit)
        cmd_sr <= cmd_shift[6:0];
      if (addr_bit)
        addr_sr <= addr_shift[22:0];
    end
  end

`ifdef QUAD_READ_EN
  always_ff @(posedge clk) begin
    if (rst)
      quad_mode <= 1'b0;
    else if (start)
      quad_mode <= 1'b0;
    else if (cmd_done)
      quad_mode <= (cmd_shift == QUAD_CMD);
  end
`endif

  // The first fetch fires on the last address bit, later ones as each byte finishes,
  // leaving two clk of slack before the next SCLK fall needs the new byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= 24'h0;
      mem_rd    <= 1'b0;
      load_pend <= 1'b0;
    end else begin
      mem_rd    <= addr_done | byte_done;
      load_pend <= mem_rd;
      if (addr_done)
        mem_addr <= addr_shift;
      else if (byte_done)
        mem_addr <= mem_addr + 24'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_sr <= 8'h0;
      do_reg  <= 4'h0;
    end else begin
      if (start) begin
        do_reg <= 4'h0;
      end else if (data_step) begin
`ifdef QUAD_READ_EN
        if (quad_mode) begin
          do_reg  <= data_sr[7:4];
          data_sr <= {data_sr[3:0], 4'h0};
        end else begin
          do_reg  <= {2'b00, data_sr[7], 1'b0};
          data_sr <= {data_sr[6:0], 1'b0};
        end
`else
        do_reg  <= {2'b00, data_sr[7], 1'b0};
        data_sr <= {data_sr[6:0], 1'b0};
`endif
      end
      if (load_pend)
        data_sr <= mem_rdata;
    end
  end

  assign dout = do_reg & ~oeb;

endmodule

// File: tb/tb_spi_rom_responder.sv
// tb_spi_rom_responder: directed SPI reads against a behavioural backing store;
// fetch addresses are scoreboarded in a queue and popped by a mem_rd monitor.
module tb_spi_rom_responder;

  localparam int HALF = 8;

  logic        clk;
  logic        rst;
  logic        cs_n;
  logic        sclk;
  logic [3:0]  di;
  logic [3:0]  dout;
  logic [3:0]  oeb;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        active;

  int          checks;
  int          failures;
  logic [23:0] exp_addr[$];
  logic [23:0] mon_addr;
  logic [3:0]  tb_do;
  logic [3:0]  tb_oeb;
  logic [7:0]  exp_byte;
  logic [23:0] cur_addr;

  spi_rom_responder dut (
    .clk       (clk),
    .rst       (rst),
    .cs_n      (cs_n),
    .sclk      (sclk),
    .di        (di),
    .dout      (dout),
    .oeb       (oeb),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .active    (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_value(input logic [23:0] a);
    case (a)
      24'h000010: mem_value = 8'hA5;
      24'h000011: mem_value = 8'h3C;
      24'h000020: mem_value = 8'h5A;
      default:    mem_value = a[7:0] + a[15:8] + a[23:16] + 8'h96;
    endcase
  endfunction

  // Backing store: data valid exactly one clk after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd)
      mem_rdata <= mem_value(mem_addr);
    else
      mem_rdata <= 8'hE7;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mem_rd) begin
      if (exp_addr.size() == 0) begin
        checkOutput("mem_rd_unexpected", 32'(mem_rd), 32'd0);
      end else begin
        mon_addr = exp_addr.pop_front();
        checkOutput("mem_rd_addr", 32'(mem_addr), 32'(mon_addr));
      end
    end
  end

  // One SCLK cycle: drive io while low, sample outputs just before the rise, end on the fall.
  task automatic applyStimulus(input logic [3:0] d, output logic [3:0] seen_do, output logic [3:0] seen_oeb);
    di = d;
    repeat (HALF) @(negedge clk);
    seen_do  = dout;
    seen_oeb = oeb;
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--)
      applyStimulus({3'b000, b[i]}, tb_do, tb_oeb);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 23; i >= 0; i--)
      applyStimulus({3'b000, a[i]}, tb_do, tb_oeb);
  endtask

  task automatic begin_txn();
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("active_when_selected", 32'(active), 32'd1);
  endtask

  task automatic end_txn();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    di   = 4'h0;
    repeat (8) @(negedge clk);
    checkOutput("oeb_after_cs_high", 32'(oeb), 32'hF);
    checkOutput("dout_after_cs_high", 32'(dout), 32'h0);
    checkOutput("active_after_cs_high", 32'(active), 32'd0);
    checkOutput("fetch_queue_drained", 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic read_single(input logic [23:0] addr, input int nbytes);
    begin_txn();
    send_byte(8'h03);
    exp_addr.push_back(addr);
    send_addr(addr);
    for (int k = 0; k < nbytes; k++) begin
      cur_addr = addr + 24'(k);
      exp_byte = mem_value(cur_addr);
      exp_addr.push_back(cur_addr + 24'd1);
      for (int i = 7; i >= 0; i--) begin
        applyStimulus(4'h0, tb_do, tb_oeb);
        checkOutput("miso_bit", 32'(tb_do), 32'({2'b00, exp_byte[i], 1'b0}));
        checkOutput("oeb_single", 32'(tb_oeb), 32'hD);
      end
    end
    end_txn();
  endtask

  // Unsupported command or aborted stream: nothing may be driven for n cycles.
  task automatic expect_quiet(input int n, input logic [3:0] d);
    for (int i = 0; i < n; i++) begin
      applyStimulus(d, tb_do, tb_oeb);
      checkOutput("oeb_quiet", 32'(tb_oeb), 32'hF);
      checkOutput("dout_quiet", 32'(tb_do), 32'h0);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    cs_n      = 1'b1;
    sclk      = 1'b0;
    di        = 4'h0;
    mem_rdata = 8'h00;
    repeat (4) @(negedge clk);
    checkOutput("rst_oeb", 32'(oeb), 32'hF);
    checkOutput("rst_dout", 32'(dout), 32'h0);
    checkOutput("rst_mem_rd", 32'(mem_rd), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("rst_active", 32'(active), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("idle_mem_rd", 32'(mem_rd), 32'd0);
    end
    checkOutput("idle_oeb", 32'(oeb), 32'hF);

    $display("[TB] single read 0x03 @0x000010, two bytes");
    read_single(24'h000010, 2);

    $display("[TB] single read wrapping at 0xFFFFFF");
    read_single(24'hFFFFFF, 2);

    $display("[TB] unsupported 0x9F then a normal read");
    begin_txn();
    send_byte(8'h9F);
    expect_quiet(32, 4'h1);
    end_txn();
    read_single(24'h000010, 1);

    $display("[TB] abort after 12 address bits then read 0x000004");
    begin_txn();
    send_byte(8'h03);
    for (int i = 23; i >= 12; i--)
      applyStimulus({3'b000, 1'b1}, tb_do, tb_oeb);
    end_txn();
    read_single(24'h000004, 1);

    $display("[TB] rst asserted in the middle of DATA");
    begin_txn();
    send_byte(8'h03);
    exp_addr.push_back(24'h000030);
    send_addr(24'h000030);
    exp_byte = mem_value(24'h000030);
    for (int i = 7; i >= 5; i--) begin
      applyStimulus(4'h0, tb_do, tb_oeb);
      checkOutput("pre_rst_miso", 32'(tb_do), 32'({2'b00, exp_byte[i], 1'b0}));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_mid_oeb", 32'(oeb), 32'hF);
    checkOutput("rst_mid_dout", 32'(dout), 32'h0);
    checkOutput("rst_mid_mem_addr", 32'(mem_addr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h03);
    expect_quiet(24, 4'h1);
    end_txn();
    read_single(24'h000011, 1);

`ifdef QUAD_READ_EN
    $display("[TB] quad read 0x6B @0x000020");
    begin_txn();
    send_byte(8'h6B);
    exp_addr.push_back(24'h000020);
    send_addr(24'h000020);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'h0, tb_do, tb_oeb);
      checkOutput("oeb_dummy", 32'(tb_oeb), 32'hF);
    end
    for (int k = 0; k < 2; k++) begin
      cur_addr = 24'h000020 + 24'(k);
      exp_byte = mem_value(cur_addr);
      exp_addr.push_back(cur_addr + 24'd1);
      applyStimulus(4'h0, tb_do, tb_oeb);
      checkOutput("quad_hi_nibble", 32'(tb_do), 32'(exp_byte[7:4]));
      checkOutput("oeb_quad", 32'(tb_oeb), 32'h0);
      applyStimulus(4'h0, tb_do, tb_oeb);
      checkOutput("quad_lo_nibble", 32'(tb_do), 32'(exp_byte[3:0]));
      checkOutput("oeb_quad", 32'(tb_oeb), 32'h0);
    end
    end_txn();
`else
    $display("[TB] 0x6B without quad support behaves as unsupported");
    begin_txn();
    send_byte(8'h6B);
    expect_quiet(32, 4'h1);
    end_txn();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_rom_responder.md
SPI_ROM_RESPONDER -- requirements
Module: spi_rom_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports below are listed as name, direction, width, meaning.
REQ-002 clk  input  1  system clock; must run at least 8x the SCLK frequency.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 cs_n  input  1  chip select from the initiator, active low, asynchronous to clk.
REQ-005 sclk  input  1  serial clock from the initiator (SPI mode 0), asynchronous to clk.
REQ-006 di  input  4  pad inputs io[3:0]; io0 is MOSI during command and address.
REQ-007 do  output  4  pad outputs io[3:0]; io1 is MISO in single mode.
REQ-008 oeb  output  4  output-enable bar per pad (0 = drive, 1 = hi-Z).
REQ-009 mem_addr  output  24  byte address presented to the backing store.
REQ-010 mem_rd  output  1  one-clk read strobe.
REQ-011 mem_rdata  input  8  backing-store data, valid exactly 1 clk after mem_rd.
REQ-012 active  output  1  high while cs_n is synchronised low.

Function
REQ-013 cs_n, sclk and di SHALL each pass through a 2-FF synchroniser; SCLK rise and fall SHALL be detected from the synchronised sclk.
REQ-014 States SHALL be IDLE, CMD, ADDR, DUMMY, DATA and IGNORE.
REQ-015 Synchronised cs_n high SHALL force IDLE in every state, with oeb=4'hF, on the next clk.
REQ-016 IDLE SHALL go to CMD on a synchronised cs_n falling edge, clearing the bit counter.
REQ-017 CMD SHALL shift 8 bits from io0, MSB first, on SCLK rises.
REQ-018 Command 0x03 SHALL go to ADDR; any unsupported command SHALL go to IGNORE, which holds oeb=4'hF until cs_n rises.
REQ-019 ADDR SHALL shift 24 address bits, MSB first, from io0.
REQ-020 On the SCLK rise carrying the last address bit, the block SHALL assert mem_rd for 1 clk with mem_addr equal to the received address.
REQ-021 mem_rdata SHALL be loaded into the output shift register 1 clk after mem_rd.
REQ-022 DATA single mode: on each SCLK fall, do[1] SHALL present the next bit, MSB first.
REQ-023 DATA single mode: oeb SHALL be 4'b1101 (only io1 driven).
REQ-024 The first data bit SHALL be valid on the first SCLK fall after the last address rise.
REQ-025 In DATA, after the 8th bit of a byte is shifted out, mem_addr SHALL increment and mem_rd SHALL pulse, so the next byte is loaded before its first SCLK fall; reads are continuous.
REQ-026 mem_addr SHALL wrap from 24'hFFFFFF to 24'h000000.
REQ-027 do bits that are not driven SHALL read 0.
REQ-028 active SHALL equal the inverted synchronised cs_n.

Reset
REQ-029 On rst, state SHALL be IDLE.
REQ-030 On rst, do=4'h0, oeb=4'hF, mem_addr=24'h0, mem_rd=0, active=0, and all counters and shift registers SHALL clear.
REQ-031 rst mid-transaction SHALL abort; the block SHALL ignore bus activity until a fresh cs_n falling edge after rst deasserts.

Configuration
REQ-032 Macro QUAD_READ_EN SHALL compile in support for command 0x6B (quad output fast read).
REQ-033 With QUAD_READ_EN defined, 0x6B SHALL go ADDR -> DUMMY (8 SCLK cycles, oeb=4'hF) -> DATA.
REQ-034 In quad DATA, each SCLK fall SHALL present a nibble on do[3:0], high nibble first, with oeb=4'h0.
REQ-035 In quad DATA, 2 SCLK cycles SHALL make one byte; address increment, fetch and wrap SHALL behave as in single mode.
REQ-036 In quad mode, mem_rd for the first byte SHALL fire at the last address rise, and the byte SHALL be valid before the first DUMMY->DATA fall.
REQ-037 Without QUAD_READ_EN, 0x6B SHALL be treated as unsupported (IGNORE), and no DUMMY state or quad datapath SHALL be synthesised.

Verification
REQ-038 Reset then idle bus -> oeb=4'hF, do=0, mem_rd never asserted.
REQ-039 cs_n low, send 0x03, address 0x000010, 16 SCLK cycles with store[0x10]=0xA5, store[0x11]=0x3C -> MISO bits 10100101 00111100; mem_rd at addresses 0x10 then 0x11.
REQ-040 Read 0x03 at 0xFFFFFF for 2 bytes -> second mem_addr = 0x000000.
REQ-041 Command 0x9F -> oeb stays 4'hF and mem_rd stays 0 through 40 SCLK cycles; after cs_n high then low, a following 0x03 read works.
REQ-042 cs_n high after 12 address bits, then a new 0x03 read at 0x000004 -> first byte is store[0x04]; rst asserted mid-DATA -> oeb=4'hF on the next clk.
REQ-043 With QUAD_READ_EN: 0x6B at 0x000020, store=0x5A, 8 dummy cycles -> do[3:0]=4'h5 then 4'hA, oeb=4'h0 only in DATA; without the macro -> IGNORE behaviour.
